// File: rtl/vga_timing_pkg.sv
// Shared raster timing definitions for the VGA timing generator.
// Phase encoding, default 640x480@60 timing and boundary helpers.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int axis_total(
    input int act, input int fp,
    input int syn, input int bp);
    return act + fp + syn + bp;
  endfunction

  // Last count value of each region, in phase order.
  function automatic int end_active(input int act);
    return act - 1;
  endfunction

  function automatic int end_front(
    input int act, input int fp);
    return act + fp - 1;
  endfunction

  function automatic int end_sync(
    input int act, input int fp, input int syn);
    return act + fp + syn - 1;
  endfunction

endpackage

// File: rtl/vga_timing_gen_raster_axis_ctr.sv
// One raster axis: position counter plus region phase FSM.
// Shared by the horizontal and vertical axes.
module raster_axis_ctr
  import vga_timing_pkg::*;
#(
  parameter int ACT = 640,
  parameter int FP  = 16,
  parameter int SYN = 96,
  parameter int BP  = 48,
  parameter int W   = 10
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         adv,
  output logic         wrap,
  output logic [W-1:0] count,
  output phase_e       phase,
  output phase_e       nxt_phase
);

  localparam int TOT = axis_total(ACT, FP, SYN, BP);

  localparam logic [W-1:0] E_ACT  = W'(end_active(ACT));
  localparam logic [W-1:0] E_FP   = W'(end_front(ACT, FP));
  localparam logic [W-1:0] E_SYN  = W'(end_sync(ACT, FP, SYN));
  localparam logic [W-1:0] E_LAST = W'(TOT - 1);

  logic [W-1:0] nxt_count;

  always_comb begin
    wrap      = adv && (count == E_LAST);
    nxt_count = count;
    if (adv) begin
      nxt_count = wrap ? '0 : count + 1'b1;
    end
  end

  // Phase moves on the advance that leaves the current region.
  always_comb begin
    nxt_phase = phase;
    if (adv) begin
      unique case (phase)
        PH_ACTIVE: if (count == E_ACT)  nxt_phase = PH_FRONT;
        PH_FRONT:  if (count == E_FP)   nxt_phase = PH_SYNC;
        PH_SYNC:   if (count == E_SYN)  nxt_phase = PH_BACK;
        PH_BACK:   if (count == E_LAST) nxt_phase = PH_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= E_LAST;
      phase <= PH_BACK;
    end else begin
      count <= nxt_count;
      phase <= nxt_phase;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: syncs, display enable, coordinates, pulses.
// Decoded outputs are registered from next-state so they align with counters.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int X_W      = 10,
  parameter int Y_W      = 10
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           pixelEn,
  output logic           hsync,
  output logic           vsync,
  output logic           displayEn,
  output logic [X_W-1:0] pixelX,
  output logic [Y_W-1:0] pixelY,
  output logic           lineStart,
  output logic           frameStart,
  output logic           vblank
);

  localparam int H_TOTAL =
    axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL =
    axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_ACTIVE < 1 || H_FP < 1 ||
      H_SYNC < 1 || H_BP < 1) begin : g_bad_h
    $error("vga_timing_gen: bad horizontal timing");
  end
  if (V_ACTIVE < 1 || V_FP < 1 ||
      V_SYNC < 1 || V_BP < 1) begin : g_bad_v
    $error("vga_timing_gen: bad vertical timing");
  end
  if (X_W < 1 || X_W > 30 ||
      ((H_TOTAL - 1) >> X_W) != 0) begin : g_bad_xw
    $error("vga_timing_gen: X_W too narrow");
  end
  if (Y_W < 1 || Y_W > 30 ||
      ((V_TOTAL - 1) >> Y_W) != 0) begin : g_bad_yw
    $error("vga_timing_gen: Y_W too narrow");
  end

  logic   h_wrap;
  logic   v_wrap;
  phase_e h_phase;
  phase_e v_phase;
  phase_e h_nxt;
  phase_e v_nxt;

  raster_axis_ctr #(
    .ACT(H_ACTIVE), .FP(H_FP),
    .SYN(H_SYNC), .BP(H_BP), .W(X_W)
  ) u_h (
    .clk      (clk),
    .resetn   (resetn),
    .adv      (pixelEn),
    .wrap     (h_wrap),
    .count    (pixelX),
    .phase    (h_phase),
    .nxt_phase(h_nxt)
  );

  raster_axis_ctr #(
    .ACT(V_ACTIVE), .FP(V_FP),
    .SYN(V_SYNC), .BP(V_BP), .W(Y_W)
  ) u_v (
    .clk      (clk),
    .resetn   (resetn),
    .adv      (h_wrap),
    .wrap     (v_wrap),
    .count    (pixelY),
    .phase    (v_phase),
    .nxt_phase(v_nxt)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hsync      <= !H_POL;
      vsync      <= !V_POL;
      displayEn  <= 1'b0;
      vblank     <= 1'b1;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      hsync      <= (h_nxt == PH_SYNC) ? H_POL : !H_POL;
      vsync      <= (v_nxt == PH_SYNC) ? V_POL : !V_POL;
      displayEn  <= (h_nxt == PH_ACTIVE) &&
                    (v_nxt == PH_ACTIVE);
      vblank     <= (v_nxt != PH_ACTIVE);
      lineStart  <= h_wrap;
      frameStart <= v_wrap;
    end
  end

endmodule
